graphics_pixel_writer: RTL

GRAPHICS_PIXEL_WRITER -- requirements
Module: graphics_pixel_writer

---
 rtl/graphics_pixel_writer_if.sv | 26 ++
 rtl/graphics_pixel_writer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/graphics_pixel_writer_if.sv
// Pixel writer bus bundle: Avalon-ST pixel sink (readyLatency 1) plus Avalon-MM write master.
// The master modport is the writer side; the slave modport is the source/memory side.
interface graphics_pixel_writer_if #(
   parameter int ST_DATA_WIDTH     = 32,
   parameter int MM_MEM_ADDR_WIDTH = 32,
   parameter int MM_MEM_DATA_WIDTH = 16
);
   logic                           st_ready;
   logic [ST_DATA_WIDTH-1:0]       st_data;
   logic                           st_valid;
   logic                           mm_write;
   logic [MM_MEM_ADDR_WIDTH-1:0]   mm_address;
   logic [MM_MEM_DATA_WIDTH-1:0]   mm_writedata;
   logic [MM_MEM_DATA_WIDTH/8-1:0] mm_byteenable;
   logic                           mm_waitrequest;

   modport master (
      output st_ready, mm_write, mm_address, mm_writedata, mm_byteenable,
      input  st_data, st_valid, mm_waitrequest
   );

   modport slave (
      input  st_ready, mm_write, mm_address, mm_writedata, mm_byteenable,
      output st_data, st_valid, mm_waitrequest
   );
endinterface

// File: rtl/graphics_pixel_writer.sv
// Buffers {x, y, color} pixel beats and writes each color to its frame-buffer word in SDRAM.
// Define GRAPHICS_PIXEL_WRITER_CLIP_EN to discard off-screen pixels at acceptance.
module graphics_pixel_writer #(
   parameter int unsigned MM_START_ADDRESS  = 0,
   parameter int          BUFFER_DEPTH      = 4,
   parameter int          MM_MEM_ADDR_WIDTH = 32,
   parameter int          MM_MEM_DATA_WIDTH = 16,
   parameter int          COORD_WIDTH       = 11,
   parameter int          COLOR_DATA_WIDTH  = 8,
   parameter int          ST_DATA_WIDTH     = 32,
   parameter int          WIDTH             = 640,
   parameter int          HEIGHT            = 480
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         clken,
   graphics_pixel_writer_if.master      bus,
   input  logic                         flush,
   output logic                         flush_done,
   output logic                         busy,
   output logic [31:0]                  write_count,
   output logic [31:0]                  clip_count
);
   localparam int BYTES = MM_MEM_DATA_WIDTH / 8;
   localparam int PTR_W = $clog2(BUFFER_DEPTH);
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
   localparam int PAD_W = ST_DATA_WIDTH - 2 * COORD_WIDTH - COLOR_DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StActive, StFlush, StFlushDone} state_e;

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
   logic                         rdy_prev_q;
   logic [31:0]                  write_count_q;
   logic [MM_MEM_ADDR_WIDTH-1:0] addr_mem [BUFFER_DEPTH];
   logic [COLOR_DATA_WIDTH-1:0]  color_mem [BUFFER_DEPTH];

   logic signed [COORD_WIDTH-1:0] pix_x, pix_y;
   logic [COLOR_DATA_WIDTH-1:0]   pix_color;
   logic [63:0]                   addr_full;
   logic                          accept, push, pop, mm_write;

   assign pix_x     = bus.st_data[ST_DATA_WIDTH-1 -: COORD_WIDTH];
   assign pix_y     = bus.st_data[ST_DATA_WIDTH-1-COORD_WIDTH -: COORD_WIDTH];
   assign pix_color = bus.st_data[ST_DATA_WIDTH-1-2*COORD_WIDTH -: COLOR_DATA_WIDTH];

   // Signed 64-bit arithmetic so negative coordinates wrap like the truncated address should.
   always_comb begin
      longint lin;
      lin       = longint'(pix_y) * longint'(WIDTH) + longint'(pix_x);
      addr_full = longint'(MM_START_ADDRESS) + lin * longint'(BYTES);
   end

   // A beat is legal, and must be taken, whenever ready was high the cycle before.
   assign accept = bus.st_valid & rdy_prev_q;
   assign mm_write = (cnt_q != '0);
   assign pop      = mm_write & ~bus.mm_waitrequest;

`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
   logic        oob, clip;
   logic [31:0] clip_count_q;
   assign oob  = (longint'(pix_x) < 0) || (longint'(pix_x) >= longint'(WIDTH)) ||
                 (longint'(pix_y) < 0) || (longint'(pix_y) >= longint'(HEIGHT));
   assign clip = accept & oob;
   assign push = accept & ~oob;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) clip_count_q <= '0;
      else if (clip) clip_count_q <= clip_count_q + 32'd1;
   end
   assign clip_count = clip_count_q;
`else
   assign push       = accept;
   assign clip_count = '0;
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
   end

   function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Reserve a slot for the beat that may still land this cycle from last cycle's ready.
   assign bus.st_ready = reset_n & clken &
                         ((32'(cnt_q) + 32'(rdy_prev_q)) < 32'(BUFFER_DEPTH));

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q]  <= addr_full[MM_MEM_ADDR_WIDTH-1:0];
         color_mem[wr_ptr_q] <= pix_color;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         rdy_prev_q    <= 1'b0;
         write_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdy_prev_q <= bus.st_ready;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) begin
            rd_ptr_q      <= ptr_inc(rd_ptr_q);
            write_count_q <= write_count_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (flush) state_d = StFlush;
            else if (accept) state_d = StActive;
         end
         StActive: begin
            if (flush) state_d = StFlush;
            else if (cnt_d == '0) state_d = StIdle;
         end
         StFlush:     if (cnt_d == '0) state_d = StFlushDone;
         StFlushDone: state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   assign bus.mm_write      = mm_write;
   assign bus.mm_address    = mm_write ? addr_mem[rd_ptr_q] : '0;
   assign bus.mm_writedata  = mm_write ? MM_MEM_DATA_WIDTH'(color_mem[rd_ptr_q]) : '0;
   assign bus.mm_byteenable = '1;
   assign flush_done        = (state_q == StFlushDone);
   assign busy              = mm_write;
   assign write_count       = write_count_q;

   logic unused_bits;
   assign unused_bits = ^{addr_full[63:MM_MEM_ADDR_WIDTH], bus.st_data[PAD_W-1:0]};
endmodule
